// File: rtl/invader_fire_sched.sv
// Enemy projectile scheduler: cooldown, round-robin column pick, slot allocation, spawn handshake.
// Optional FIRE_LFSR_EN: pseudo-random starting column for each arbitration.
module invader_fire_sched #(
  parameter int NUM_COLS    = 6,
  parameter int NUM_SLOTS   = 3,
  parameter int FIRE_PERIOD = 24
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                frame,
  input  logic                                                enable,
  input  logic [NUM_COLS-1:0]                                 col_alive,
  input  logic [NUM_SLOTS-1:0]                                slot_release,
  input  logic                                                spawn_ready,
  output logic                                                spawn_valid,
  output logic [$clog2(NUM_COLS)-1:0]                         spawn_col,
  output logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] spawn_slot,
  output logic [NUM_SLOTS-1:0]                                slot_busy
);

  localparam int COL_W  = $clog2(NUM_COLS);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {COOL, ARB, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cooldown;
  logic [COL_W-1:0]    rr;
  logic                grant_found, slot_found, arb_load, accept;
  logic [COL_W-1:0]    grant_col;
  logic [SLOT_W-1:0]   free_slot;
  logic [NUM_SLOTS-1:0] set_mask;
  int                  idx;

  // First alive column at or after rr (wrapping), and lowest free slot
  always_comb begin
    grant_found = 1'b0;
    grant_col   = '0;
    idx         = 0;
    for (int k = NUM_COLS - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % NUM_COLS;
      if (col_alive[idx]) begin
        grant_found = 1'b1;
        grant_col   = COL_W'(idx);
      end
    end
    slot_found = 1'b0;
    free_slot  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_busy[i]) begin
        slot_found = 1'b1;
        free_slot  = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    arb_load = 1'b0;
    accept   = 1'b0;
    case (state_q)
      COOL:  if (enable && cooldown == 8'd0) state_d = ARB;
      ARB: begin
        if (!enable) begin
          state_d = COOL;
        end else if (grant_found && slot_found) begin
          state_d  = ISSUE;
          arb_load = 1'b1;
        end
      end
      ISSUE: begin
        if (spawn_ready) begin
          accept  = 1'b1;
          state_d = COOL;
        end
      end
      default: state_d = COOL;
    endcase
    for (int i = 0; i < NUM_SLOTS; i++) begin
      set_mask[i] = accept && (int'(spawn_slot) == i);
    end
  end

  assign spawn_valid = (state_q == ISSUE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= COOL;
    else     state_q <= state_d;
  end

`ifdef FIRE_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (rst)        lfsr <= 8'h5A;
    else if (frame) lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cooldown   <= 8'(FIRE_PERIOD);
      rr         <= '0;
      slot_busy  <= '0;
      spawn_col  <= '0;
      spawn_slot <= '0;
    end else begin
      // A slot being accepted is free, so a release of it cannot collide with the set
      slot_busy <= (slot_busy & ~slot_release) | set_mask;
      if (state_q == COOL && frame && enable && cooldown != 8'd0) begin
        cooldown <= cooldown - 8'd1;
      end
      if (accept) begin
        cooldown <= 8'(FIRE_PERIOD);
        rr       <= (int'(spawn_col) == NUM_COLS - 1) ? '0 : spawn_col + 1'b1;
      end
      if (arb_load) begin
        spawn_col  <= grant_col;
        spawn_slot <= free_slot;
      end
`ifdef FIRE_LFSR_EN
      if (state_q == COOL && state_d == ARB) begin
        rr <= COL_W'(int'(lfsr[3:0]) % NUM_COLS);
      end
`endif
    end
  end

endmodule

// File: doc/invader_fire_sched.md
# invader_fire_sched

Scheduler for enemy (invader) projectiles. Shares a fixed pool of enemy-laser slots among invader columns: each frame it counts down a fire cooldown, picks the next eligible column round-robin, allocates a free slot, and hands a spawn request to the projectile datapath over a valid/ready handshake. Sits between invader-grid state (column alive mask) and the enemy-laser datapath, which returns slot-release pulses on hit or off-screen.

## Interface
- NUM_COLS, 6, invader columns (requesters); 2..16
- NUM_SLOTS, 3, concurrent enemy lasers; 1..8
- FIRE_PERIOD, 24, frames between spawns; 1..255
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- frame  in  1  one-cycle pulse at start of blanking interval
- enable  in  1  1 = game running; 0 freezes cooldown, suppresses new arbitration
- col_alive  in  NUM_COLS  bit i = column i has a living invader
- slot_release  in  NUM_SLOTS  one-cycle pulse per slot freed by datapath
- spawn_ready  in  1  datapath accepts spawn this cycle
- spawn_valid  out  1  spawn request pending
- spawn_col  out  $clog2(NUM_COLS)  column to fire from; stable while spawn_valid
- spawn_slot  out  $clog2(NUM_SLOTS)  slot to fill; stable while spawn_valid
- slot_busy  out  NUM_SLOTS  allocation map

## Operation
- States: COOL, ARB, ISSUE.
- Reset: state COOL, cooldown = FIRE_PERIOD, rr pointer = 0, slot_busy = 0, spawn_valid = 0, spawn_col = 0, spawn_slot = 0.
- COOL: on frame && enable, cooldown decrements (8-bit, saturates at 0). When cooldown == 0 and enable, go ARB next cycle.
- ARB (one cycle): eligible = col_alive. Grant = first set bit of eligible searching from rr pointer upward, wrapping at NUM_COLS. Slot = lowest-index clear bit of slot_busy. If grant and slot found: latch spawn_col/spawn_slot, go ISSUE. Else (no alive column or all slots busy): stay in ARB, retry every cycle; cooldown stays 0.
- ARB exits to COOL (cooldown unchanged) if enable drops.
- ISSUE: spawn_valid = 1. On spawn_valid && spawn_ready: set slot_busy[spawn_slot], rr pointer = spawn_col + 1 (mod NUM_COLS), cooldown = FIRE_PERIOD, go COOL. spawn_valid drops the next cycle. enable dropping in ISSUE does not withdraw the request.
- slot_release[i] clears slot_busy[i] every cycle regardless of state. Release and acceptance of the same slot in one cycle cannot occur (slot was free); releases of other slots apply in parallel with set.
- Release of an already-free slot: ignored.
- col_alive changing during ISSUE: request not withdrawn; datapath handles dead column.
- rst mid-ISSUE: request dropped, all slots freed, outputs to reset values next edge.

## Timing
- Cooldown expiry to spawn_valid: 2 cycles (COOL→ARB→ISSUE) when resources available.
- Handshake completes same cycle spawn_ready sampled high; slot_busy reflects allocation one cycle after acceptance.
- slot_release to slot reusable in ARB: 1 cycle.
- frame arriving during ARB/ISSUE: ignored for counting.
- Minimum spawn interval: FIRE_PERIOD frames.

## Configuration
- FIRE_LFSR_EN defined: 8-bit Galois LFSR (taps 0xB8, seed 0x5A at reset) steps every frame; on entering ARB, rr pointer is replaced by LFSR[3:0] mod NUM_COLS before search, giving pseudo-random column choice. Post-accept rr update is still performed but overwritten at next ARB.
- Undefined: pure round-robin as above; no LFSR logic.

## Test plan
- Reset, enable=1, col_alive=6'b111111, spawn_ready=1, FIRE_PERIOD=24 -> first spawn_valid 2 cycles after 24th frame, col 0 slot 0; next spawns col 1 slot 1, col 2 slot 2, 24 frames apart.
- col_alive=6'b100100, rr=0 -> grants col 2, then col 5, then col 2 (wrap).
- All 3 slots busy at expiry -> stays in ARB, spawn_valid=0; slot_release=3'b010 -> spawn on slot 1 within 2 cycles.
- spawn_ready held 0 for 10 cycles -> spawn_valid, spawn_col, spawn_slot stable; slot_busy unchanged until accept.
- enable=0 for 30 frames -> cooldown frozen, no spawn; col_alive=0 at expiry -> no spawn until a column set.
- rst asserted during ISSUE -> next cycle spawn_valid=0, slot_busy=0, cooldown=FIRE_PERIOD.
